// File: rtl/banner_pkg.sv
// Shared constants and types for the banner row streamer: ROM geometry, FSM states
// and the compare-subtract row-index wrap helper.
package banner_pkg;

    localparam int ROW_W     = 57;
    localparam int ROM_DEPTH = 129;
    localparam int ADDR_W    = 8;

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(ROM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    // base + step, folded back into 0..ROM_DEPTH-1; valid while base + step < 2*ROM_DEPTH
    function automatic logic [ADDR_W-1:0] wrap_row(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] step);
        logic [ADDR_W:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= DEPTH_EXT) begin
            sum = sum - DEPTH_EXT;
        end
        return sum[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/banner_row_shifter.sv
// Row serialiser: active shift register, prefetch hold register and column counter.
// Build option BANNER_MIRROR_EN emits each row LSB first instead of MSB first.
module banner_row_shifter
    import banner_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_row,
    input  logic             load_hold,
    input  logic             accept,
    input  logic             more_rows,
    input  logic [ROW_W-1:0] rom_data,
    output logic             pix_bit,
    output logic             eol
);
    localparam int COL_W = $clog2(ROW_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_W - 1);

    logic [ROW_W-1:0] shift_reg;
    logic [ROW_W-1:0] hold_reg;
    logic [ROW_W-1:0] shift_next;
    logic [COL_W-1:0] col_reg;

`ifdef BANNER_MIRROR_EN
    assign pix_bit    = shift_reg[0];
    assign shift_next = {1'b0, shift_reg[ROW_W-1:1]};
`else
    assign pix_bit    = shift_reg[ROW_W-1];
    assign shift_next = {shift_reg[ROW_W-2:0], 1'b0};
`endif

    assign eol = (col_reg == LAST_COL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            hold_reg  <= '0;
            col_reg   <= '0;
        end else begin
            if (load_hold) begin
                hold_reg <= rom_data;
            end
            if (load_row) begin
                shift_reg <= rom_data;
                col_reg   <= '0;
            end else if (accept) begin
                if (eol) begin
                    // the prefetched row takes over on the same edge, so rows abut
                    col_reg <= '0;
                    if (more_rows) begin
                        shift_reg <= hold_reg;
                    end
                end else begin
                    col_reg   <= col_reg + 1'b1;
                    shift_reg <= shift_next;
                end
            end
        end
    end

endmodule

// File: rtl/banner_row_streamer.sv
// Fetches WINDOW banner rows per frame from a registered ROM, streams them pixel by pixel
// and advances the scroll offset every STEP_FRAMES frames.
module banner_row_streamer
    import banner_pkg::*;
#(
    parameter int WINDOW      = 16,
    parameter int STEP_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROW_W-1:0]  rom_data,
    output logic              pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              frame_done,
    output logic [ADDR_W-1:0] scroll_offset
);
    localparam int FC_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [ADDR_W:0]   WIN_EXT    = (ADDR_W+1)'(WINDOW);
    localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(WINDOW - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ROM_DEPTH - 1);
    localparam logic [FC_W-1:0]   LAST_FRAME = FC_W'(STEP_FRAMES - 1);
    localparam logic              MULTI_ROW  = (WINDOW > 1);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] row_cnt_reg;
    logic [FC_W-1:0]   frame_cnt_reg;
    logic [ADDR_W-1:0] scroll_offset_reg;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic              frame_done_reg;
    logic [1:0]        fetch_pipe_reg;

    logic              shifting;
    logic              accept;
    logic              pix_bit;
    logic              eol;
    logic              last_row;
    logic              eof_accept;
    logic              row_accept;
    logic [ADDR_W:0]   ahead2;
    logic [ADDR_W-1:0] fetch_step;
    logic              fetch_issue;
    logic [ADDR_W-1:0] offset_after;

    assign shifting   = (state_reg == SHIFT);
    assign accept     = shifting & pix_ready;
    assign last_row   = (row_cnt_reg == LAST_ROW);
    assign eof_accept = accept & eol & last_row;
    assign row_accept = accept & eol & ~last_row;

    // Prefetch runs one row ahead: LOAD fetches row 1, each row end fetches row_cnt+2
    assign ahead2      = {1'b0, row_cnt_reg} + (ADDR_W+1)'(2);
    assign fetch_step  = (state_reg == LOAD) ? ADDR_W'(1) : ahead2[ADDR_W-1:0];
    assign fetch_issue = ((state_reg == LOAD) & MULTI_ROW) | (row_accept & (ahead2 < WIN_EXT));

    always_comb begin
        offset_after = scroll_offset_reg;
        if (frame_cnt_reg == LAST_FRAME) begin
            offset_after = (scroll_offset_reg == LAST_ADDR) ? '0 : scroll_offset_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = ADDR;
            ADDR:    state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (eof_accept) state_next = enable ? ADDR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            row_cnt_reg       <= '0;
            frame_cnt_reg     <= '0;
            scroll_offset_reg <= '0;
            rom_addr_reg      <= '0;
            frame_done_reg    <= 1'b0;
            fetch_pipe_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            frame_done_reg <= eof_accept;
            fetch_pipe_reg <= {fetch_pipe_reg[0], fetch_issue};

            // first row of the next frame already uses the stepped offset
            if ((state_reg == IDLE) && enable) begin
                rom_addr_reg <= scroll_offset_reg;
            end else if (eof_accept) begin
                rom_addr_reg <= offset_after;
            end else if (fetch_issue) begin
                rom_addr_reg <= wrap_row(scroll_offset_reg, fetch_step);
            end

            if (eof_accept) begin
                row_cnt_reg       <= '0;
                frame_cnt_reg     <= (frame_cnt_reg == LAST_FRAME) ? '0 : frame_cnt_reg + 1'b1;
                scroll_offset_reg <= offset_after;
            end else if (row_accept) begin
                row_cnt_reg <= row_cnt_reg + 1'b1;
            end
        end
    end

    banner_row_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load_row  (state_reg == LOAD),
        .load_hold (fetch_pipe_reg[1]),
        .accept    (accept),
        .more_rows (~last_row),
        .rom_data  (rom_data),
        .pix_bit   (pix_bit),
        .eol       (eol)
    );

    assign rom_addr      = rom_addr_reg;
    assign scroll_offset = scroll_offset_reg;
    assign frame_done    = frame_done_reg;
    assign pix_valid     = shifting;
    assign pix_data      = shifting & pix_bit;
    assign pix_eol       = shifting & eol;
    assign pix_eof       = shifting & eol & last_row;

endmodule

// File: tb/tb_banner_row_streamer.sv
// Scoreboard bench for banner_row_streamer: two instances (16-row window / 4-frame step and
// 4-row window / 1-frame step) fed by a registered ROM model; a monitor pops expected pixels.
module tb_banner_row_streamer;
    import banner_pkg::*;

    localparam int WIN_A  = 16;
    localparam int STEP_A = 4;
    localparam int WIN_B  = 4;
    localparam int STEP_B = 1;
    localparam int FRAMES_B = 132;

    typedef struct packed {
        logic d;
        logic eol;
        logic eof;
    } pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a, enable_a, pix_ready_a;
    logic [ADDR_W-1:0] rom_addr_a, scroll_offset_a;
    logic [ROW_W-1:0]  rom_data_a;
    logic              pix_data_a, pix_valid_a, pix_eol_a, pix_eof_a, frame_done_a;

    logic              rst_b, enable_b, pix_ready_b;
    logic [ADDR_W-1:0] rom_addr_b, scroll_offset_b;
    logic [ROW_W-1:0]  rom_data_b;
    logic              pix_data_b, pix_valid_b, pix_eol_b, pix_eof_b, frame_done_b;

    banner_row_streamer #(.WINDOW(WIN_A), .STEP_FRAMES(STEP_A)) dut_a (
        .clk(clk), .rst(rst_a), .enable(enable_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .pix_data(pix_data_a), .pix_valid(pix_valid_a), .pix_ready(pix_ready_a),
        .pix_eol(pix_eol_a), .pix_eof(pix_eof_a), .frame_done(frame_done_a),
        .scroll_offset(scroll_offset_a)
    );

    banner_row_streamer #(.WINDOW(WIN_B), .STEP_FRAMES(STEP_B)) dut_b (
        .clk(clk), .rst(rst_b), .enable(enable_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .pix_data(pix_data_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready_b),
        .pix_eol(pix_eol_b), .pix_eof(pix_eof_b), .frame_done(frame_done_b),
        .scroll_offset(scroll_offset_b)
    );

    // Banner ROM contents: rows 0, 3 and 126 are the hand-specified ones, the rest are distinct.
    function automatic logic [ROW_W-1:0] rom_row(input logic [ADDR_W-1:0] a);
        case (a)
            8'd0:    rom_row = 57'd7;
            8'd3:    rom_row = 57'h1F8;
            8'd126:  rom_row = {1'b1, 56'd7};
            default: rom_row = {1'b1, a ^ 8'hA5, 40'h5A_C3_0F_96_3C, a};
        endcase
    endfunction

    always @(posedge clk) rom_data_a <= rom_row(rom_addr_a);
    always @(posedge clk) rom_data_b <= rom_row(rom_addr_b);

    pix_t exp_a[$];
    pix_t exp_b[$];
    int   exp_off_a[$];
    int   exp_off_b[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_a = 0, done_b = 0;
    int   cyc = 0, last_done_cyc_a = 0, period_a = 0;
    int   rmode_a = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void push_frame(input bit to_b, input int offset, input int window);
        pix_t p;
        logic [ROW_W-1:0] row;
        int a;
        for (int r = 0; r < window; r++) begin
            a = offset + r;
            if (a >= ROM_DEPTH) a = a - ROM_DEPTH;
            row = rom_row(a[ADDR_W-1:0]);
            for (int c = 0; c < ROW_W; c++) begin
`ifdef BANNER_MIRROR_EN
                p.d = row[c];
`else
                p.d = row[ROW_W-1-c];
`endif
                p.eol = (c == ROW_W - 1);
                p.eof = p.eol && (r == window - 1);
                if (to_b) exp_b.push_back(p);
                else exp_a.push_back(p);
            end
        end
    endfunction

    task automatic wait_done(input bit on_b, input int target, input int budget);
        int n = 0;
        while (((on_b ? done_b : done_a) < target) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if ((on_b ? done_b : done_a) < target)
            chk(on_b ? "b_frame_timeout" : "a_frame_timeout", on_b ? done_b : done_a, target);
    endtask

    initial begin
        logic pv_a, pr_a, pd_a, pe_a, pv_b, pr_b, pe_b;
        pix_t p;
        int n, highs;
        rst_a = 1'b1; rst_b = 1'b1; enable_a = 1'b1; enable_b = 1'b0;
        pix_ready_a = 1'b1; pix_ready_b = 1'b1;
        pv_a = 0; pr_a = 0; pd_a = 0; pe_a = 0; pv_b = 0; pr_b = 0; pe_b = 0;
        fork
            begin : stimulus
                repeat (3) @(posedge clk);
                #1;
                chk("reset_pix_valid", pix_valid_a, 0);
                chk("reset_rom_addr", rom_addr_a, 0);
                chk("reset_scroll_offset", scroll_offset_a, 0);
                chk("reset_frame_done", frame_done_a, 0);
                chk("reset_eol_eof", {pix_eol_a, pix_eof_a, pix_data_a}, 0);
                push_frame(0, 0, WIN_A);
                rst_a = 1'b0; rst_b = 1'b0;
                n = 0;
                while (!pix_valid_a && n < 10) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk("first_valid_latency", n, 3);
                chk("first_row_addr_prefetch", rom_addr_a, 1);
                // abort in the middle of row 0 (col 20)
                repeat (20) @(posedge clk);
                #1;
                rst_a = 1'b1;
                #1;
                chk("midframe_rst_pix_valid", pix_valid_a, 0);
                chk("midframe_rst_rom_addr", rom_addr_a, 0);
                chk("midframe_rst_scroll_offset", scroll_offset_a, 0);
                exp_a.delete();
                repeat (2) @(posedge clk);
                #1;
                for (int f = 0; f < 5; f++) begin
                    push_frame(0, f / STEP_A, WIN_A);
                    exp_off_a.push_back((f + 1) / STEP_A);
                end
                rst_a = 1'b0;
                wait_done(0, 2, 2200);
                chk("frame_period_no_bubbles", period_a, 914);
                rmode_a = 1;
                wait_done(0, 3, 2000);
                rmode_a = 0;
                wait_done(0, 4, 1000);
                repeat (100) @(posedge clk);
                #1;
                enable_a = 1'b0;
                wait_done(0, 5, 1000);
                highs = 0;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (pix_valid_a) highs++;
                end
                chk("idle_after_enable_drop", highs, 0);
                chk("a_offset_after_5_frames", scroll_offset_a, 1);
                chk("a_pixels_all_consumed", exp_a.size(), 0);

                for (int f = 0; f < FRAMES_B; f++) begin
                    push_frame(1, f % ROM_DEPTH, WIN_B);
                    exp_off_b.push_back((f + 1) % ROM_DEPTH);
                end
                enable_b = 1'b1;
                wait_done(1, FRAMES_B - 1, (FRAMES_B - 1) * 240);
                enable_b = 1'b0;
                wait_done(1, FRAMES_B, 300);
                highs = 0;
                repeat (10) begin
                    @(posedge clk); #1;
                    if (pix_valid_b) highs++;
                end
                chk("b_idle_after_enable_drop", highs, 0);
                chk("b_offset_final", scroll_offset_b, FRAMES_B % ROM_DEPTH);
                chk("b_pixels_all_consumed", exp_b.size(), 0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    cyc++;
                    pix_ready_a = (rmode_a == 1) ? ~pix_ready_a : 1'b1;
                    pix_ready_b = 1'b1;
                    if (rst_a) begin
                        pv_a = 0; pr_a = 0; pe_a = 0;
                    end else begin
                        if (pv_a && !(pr_a && pe_a)) chk("a_valid_held", pix_valid_a, 1);
                        if (pv_a && !pr_a) chk("a_stall_data_stable", pix_data_a, pd_a);
                        if (pv_a && pr_a && pe_a) chk("a_frame_done_pulse", frame_done_a, 1);
                        else if (frame_done_a) chk("a_frame_done_spurious", frame_done_a, 0);
                        if (frame_done_a) begin
                            done_a++;
                            period_a = cyc - last_done_cyc_a;
                            last_done_cyc_a = cyc;
                            if (exp_off_a.size() == 0) chk("a_unexpected_frame", exp_off_a.size(), 1);
                            else chk("a_scroll_offset", scroll_offset_a, exp_off_a.pop_front());
                            $display("dut_a frame %0d done scroll_offset=%0d", done_a, scroll_offset_a);
                        end
                        if (pix_valid_a && pix_ready_a) begin
                            if (exp_a.size() == 0) chk("a_unexpected_pixel", exp_a.size(), 1);
                            else begin
                                p = exp_a.pop_front();
                                chk("a_pix_data", pix_data_a, p.d);
                                chk("a_pix_eol", pix_eol_a, p.eol);
                                chk("a_pix_eof", pix_eof_a, p.eof);
                            end
                        end
                        pv_a = pix_valid_a; pr_a = pix_ready_a; pd_a = pix_data_a; pe_a = pix_eof_a;
                    end
                    if (rst_b) begin
                        pv_b = 0; pr_b = 0; pe_b = 0;
                    end else begin
                        if (pv_b && !(pr_b && pe_b)) chk("b_valid_held", pix_valid_b, 1);
                        if (pv_b && pr_b && pe_b) chk("b_frame_done_pulse", frame_done_b, 1);
                        else if (frame_done_b) chk("b_frame_done_spurious", frame_done_b, 0);
                        if (frame_done_b) begin
                            done_b++;
                            if (exp_off_b.size() == 0) chk("b_unexpected_frame", exp_off_b.size(), 1);
                            else chk("b_scroll_offset", scroll_offset_b, exp_off_b.pop_front());
                            $display("dut_b frame %0d done scroll_offset=%0d", done_b, scroll_offset_b);
                        end
                        if (pix_valid_b && pix_ready_b) begin
                            if (exp_b.size() == 0) chk("b_unexpected_pixel", exp_b.size(), 1);
                            else begin
                                p = exp_b.pop_front();
                                chk("b_pix_data", pix_data_b, p.d);
                                chk("b_pix_eol", pix_eol_b, p.eol);
                                chk("b_pix_eof", pix_eof_b, p.eof);
                            end
                        end
                        pv_b = pix_valid_b; pr_b = pix_ready_b; pe_b = pix_eof_b;
                    end
                end
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
